// File: rtl/btn_event.sv
// -----------------------------------------------------------------------------
// btn_event
//
// Button gesture decoder. Takes the debounced button level and turns it into
// single-clock event strobes: press, release, short press, long press,
// auto-repeat while held, and double click. All timing is counted in 1 ms
// `tick` periods, so nothing here depends on the clock frequency.
//
// Ports:
//   clk_100Mhz    in   system clock, rising edge
//   rst           in   asynchronous, active-high reset
//   tick          in   1 ms strobe, one clock wide
//   btn_db        in   debounced button level, 1 = pressed
//   held          out  registered copy of btn_db
//   press_pulse   out  strobe on every 0->1 edge of btn_db
//   release_pulse out  strobe on every 1->0 edge of btn_db
//   short_press   out  strobe for a completed short single press
//   long_press    out  strobe when a hold reaches LONG_MS ticks
//   repeat_pulse  out  strobe every REPEAT_MS ticks while held after long_press
//   double_click  out  strobe on a second press inside the DBL_MS window
//   state_dbg     out  current FSM state encoding (debug visibility)
//
// Handshake: there is no valid/ready traffic; every output is a registered,
// one-clock strobe (or level for held/state_dbg) with no back-pressure.
// -----------------------------------------------------------------------------
module btn_event #(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int DBL_MS    = 250
) (
    input  logic       clk_100Mhz,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_db,
    output logic       held,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       double_click,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_2ND  = 3'd3,
        HOLD2     = 3'd4
    } state_t;

    // Terminal counts: the event fires on the tick that finds cnt at N-1,
    // i.e. on the N-th tick after the counter was cleared.
    localparam logic [15:0] LONG_LAST = 16'(LONG_MS - 1);
    localparam logic [15:0] REP_LAST  = 16'(REPEAT_MS - 1);
    localparam logic [15:0] DBL_LAST  = 16'(DBL_MS - 1);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        btn_d;
    logic        rise, fall;
    logic        short_nx, long_nx, rep_nx, dbl_nx;

    assign rise      = btn_db & ~btn_d;
    assign fall      = ~btn_db & btn_d;
    assign held      = btn_d;
    assign state_dbg = state;

    // Next-state logic. Edges are tested before tick in every state, so an
    // edge arriving together with a tick takes its transition and the tick
    // is dropped. Every transition clears cnt.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        short_nx = 1'b0;
        long_nx  = 1'b0;
        rep_nx   = 1'b0;
        dbl_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_nx = WAIT_2ND;
                    cnt_nx   = '0;
                end else if (tick) begin
                    if (cnt == LONG_LAST) begin
                        long_nx  = 1'b1;
                        state_nx = LONG_HELD;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
            end
            LONG_HELD: begin
                // Release after a long press is silent apart from release_pulse.
                if (fall) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (tick) begin
                    if (cnt == REP_LAST) begin
                        rep_nx = 1'b1;
                        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
            end
            WAIT_2ND: begin
                // A short press is only reported once the double-click window
                // has expired without a second press.
                if (rise) begin
                    dbl_nx   = 1'b1;
                    state_nx = HOLD2;
                    cnt_nx   = '0;
                end else if (tick) begin
                    if (cnt == DBL_LAST) begin
                        short_nx = 1'b1;
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
            end
            HOLD2: begin
                if (fall) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_d         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            double_click  <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            btn_d         <= btn_db;
            press_pulse   <= rise;
            release_pulse <= fall;
            short_press   <= short_nx;
            long_press    <= long_nx;
            repeat_pulse  <= rep_nx;
            double_click  <= dbl_nx;
        end
    end

endmodule
